// File: rtl/muldiv_unit_pkg.sv
// Shared constants and types for the iterative multiply/divide unit.
package muldiv_unit_pkg;

  typedef logic [1:0] op_t;

  localparam op_t OP_MULT  = 2'd0;
  localparam op_t OP_MULTU = 2'd1;
  localparam op_t OP_DIV   = 2'd2;
  localparam op_t OP_DIVU  = 2'd3;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_CALC = 2'd1;
  localparam logic [1:0] S_FIX  = 2'd2;

  typedef enum logic {
    MODE_MUL = 1'b0,
    MODE_DIV = 1'b1
  } step_mode_e;

endpackage

// File: rtl/muldiv_unit_if.sv
// Request/result bundle between the control unit and the multiply/divide unit.
interface muldiv_unit_if
  import muldiv_unit_pkg::*;
#(
  parameter int DATA_BITS = 32
) ();

  logic                 start;
  op_t                  op;
  logic [DATA_BITS-1:0] a;
  logic [DATA_BITS-1:0] b;
  logic                 mthi;
  logic                 mtlo;
  logic [DATA_BITS-1:0] wdata;
  logic                 busy;
  logic                 done;
  logic [DATA_BITS-1:0] hi;
  logic [DATA_BITS-1:0] lo;

  modport master (
    output start, op, a, b, mthi, mtlo, wdata,
    input  busy, done, hi, lo
  );

  modport slave (
    input  start, op, a, b, mthi, mtlo, wdata,
    output busy, done, hi, lo
  );

endinterface

// File: rtl/muldiv_unit_shift_sub_step.sv
// One combinational iteration of the shared accumulator datapath:
// shift-add for multiply, restoring shift-subtract for divide.
module muldiv_unit_shift_sub_step
  import muldiv_unit_pkg::*;
#(
  parameter int DATA_BITS = 32
) (
  input  step_mode_e               mode,
  input  logic [DATA_BITS-1:0]     operand,
  input  logic [2*DATA_BITS-1:0]   acc_in,
  output logic [2*DATA_BITS-1:0]   acc_out
);

  localparam int N = DATA_BITS;

  logic [N:0] sum;
  logic [N:0] shifted;
  logic [N:0] diff;

  assign sum     = {1'b0, acc_in[2*N-1:N]} + {1'b0, operand};
  assign shifted = acc_in[2*N-1:N-1];
  assign diff    = shifted - {1'b0, operand};

  // Divide keeps the partial remainder in the upper half and shifts quotient
  // bits into the lower half; the borrow of the trial subtraction decides
  // the quotient bit. Multiply adds the multiplicand on a set LSB and shifts
  // the whole accumulator right, carry included.
  always_comb begin
    acc_out = acc_in;
    if (mode == MODE_DIV) begin
      if (diff[N]) begin
        acc_out = {shifted[N-1:0], acc_in[N-2:0], 1'b0};
      end else begin
        acc_out = {diff[N-1:0], acc_in[N-2:0], 1'b1};
      end
    end else if (acc_in[0]) begin
      acc_out = {sum, acc_in[N-1:1]};
    end else begin
      acc_out = {1'b0, acc_in[2*N-1:1]};
    end
  end

endmodule

// File: rtl/muldiv_unit.sv
// Iterative multiply/divide unit owning the HI/LO special registers.
// Operands are reduced to magnitudes on start, iterated for DATA_BITS steps,
// then sign-corrected once in the FIX state as HI/LO are written.
module muldiv_unit
  import muldiv_unit_pkg::*;
#(
  parameter int DATA_BITS = 32
) (
  input logic           clk,
  input logic           rst_n,
  muldiv_unit_if.slave  bus
);

  localparam int N     = DATA_BITS;
  localparam int CNT_W = $clog2(DATA_BITS + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_BITS);

  logic [1:0]       state;
  logic [CNT_W-1:0] cnt;
  logic [2*N-1:0]   acc;
  logic [2*N-1:0]   acc_next;
  logic [N-1:0]     operand;
  step_mode_e       mode;
  logic             neg_lo;
  logic             neg_hi;
  logic             done_q;
  logic [N-1:0]     hi_q;
  logic [N-1:0]     lo_q;

  logic             is_mul;
  logic             is_signed;
  logic             a_neg;
  logic             b_neg;
  logic             div_zero;
  logic [N-1:0]     a_mag;
  logic [N-1:0]     b_mag;
  logic [N-1:0]     res_hi;
  logic [N-1:0]     res_lo;

  assign is_mul    = (bus.op == OP_MULT) || (bus.op == OP_MULTU);
  assign is_signed = (bus.op == OP_MULT) || (bus.op == OP_DIV);
  assign a_neg     = is_signed && bus.a[N-1];
  assign b_neg     = is_signed && bus.b[N-1];
  assign a_mag     = a_neg ? -bus.a : bus.a;
  assign b_mag     = b_neg ? -bus.b : bus.b;
  assign div_zero  = !is_mul && (bus.b == '0);

  assign bus.busy = (state != S_IDLE);
  assign bus.done = done_q;
  assign bus.hi   = hi_q;
  assign bus.lo   = lo_q;

  muldiv_unit_shift_sub_step #(
    .DATA_BITS (DATA_BITS)
  ) u_step (
    .mode    (mode),
    .operand (operand),
    .acc_in  (acc),
    .acc_out (acc_next)
  );

  // Sign correction of the finished magnitude result. A zero divisor leaves
  // the all-ones quotient untouched so LO reads all ones and HI reads a.
  always_comb begin
    res_hi = acc[2*N-1:N];
    res_lo = acc[N-1:0];
    if (mode == MODE_MUL) begin
      {res_hi, res_lo} = neg_lo ? -acc : acc;
    end else begin
      res_lo = neg_lo ? -acc[N-1:0]   : acc[N-1:0];
      res_hi = neg_hi ? -acc[2*N-1:N] : acc[2*N-1:N];
    end
  end

  // Sequencer: accept a request or an mthi/mtlo write in IDLE, iterate in
  // CALC, publish the result with a one-cycle done pulse in FIX.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= S_IDLE;
      cnt     <= '0;
      acc     <= '0;
      operand <= '0;
      mode    <= MODE_MUL;
      neg_lo  <= 1'b0;
      neg_hi  <= 1'b0;
      done_q  <= 1'b0;
      hi_q    <= '0;
      lo_q    <= '0;
    end else begin
      done_q <= 1'b0;
      case (state)
        S_IDLE: begin
          if (bus.start) begin
            mode    <= is_mul ? MODE_MUL : MODE_DIV;
            operand <= is_mul ? a_mag : b_mag;
            acc     <= is_mul ? {{N{1'b0}}, b_mag} : {{N{1'b0}}, a_mag};
            neg_lo  <= (a_neg ^ b_neg) && !div_zero;
            neg_hi  <= a_neg;
            cnt     <= '0;
            state   <= S_CALC;
          end else begin
            if (bus.mthi) hi_q <= bus.wdata;
            if (bus.mtlo) lo_q <= bus.wdata;
          end
        end
        S_CALC: begin
          if (cnt == CNT_LAST) begin
            state <= S_FIX;
          end else begin
            acc <= acc_next;
            cnt <= cnt + 1'b1;
          end
        end
        S_FIX: begin
          hi_q   <= res_hi;
          lo_q   <= res_lo;
          done_q <= 1'b1;
          state  <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_muldiv_unit.sv
// Scoreboard bench for muldiv_unit: directed corner cases plus randomized
// operations compared against a plain-arithmetic reference model.
module tb_muldiv_unit;
  import muldiv_unit_pkg::*;

  localparam int N = 32;

  typedef struct {
    logic [N-1:0] hi;
    logic [N-1:0] lo;
  } exp_t;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;
  exp_t exp_q[$];
  exp_t mon_exp;
  logic [N-1:0] hi_model;
  logic [N-1:0] lo_model;

  muldiv_unit_if #(.DATA_BITS(N)) bus ();

  muldiv_unit #(.DATA_BITS(N)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // Free-running clock, rising edges at 5, 15, 25 ...
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Hard stop in case the design never settles.
  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string name, input logic [N-1:0] actual, input logic [N-1:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%h, expected 0x%h", name, actual, expected);
    end
  endtask

  // Reference results from the arithmetic definition of each instruction.
  function automatic exp_t refModel(input op_t op, input logic [N-1:0] a, input logic [N-1:0] b);
    exp_t   r;
    longint sa, sb, ua, ub, p, q, m;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = longint'({32'd0, a});
    ub = longint'({32'd0, b});
    r.hi = '0;
    r.lo = '0;
    case (op)
      OP_MULT:  begin p = sa * sb; r.hi = p[63:32]; r.lo = p[31:0]; end
      OP_MULTU: begin p = ua * ub; r.hi = p[63:32]; r.lo = p[31:0]; end
      default: begin
        if (b == '0) begin
          r.hi = a;
          r.lo = '1;
        end else begin
          if (op == OP_DIV) begin q = sa / sb; m = sa % sb; end
          else              begin q = ua / ub; m = ua % ub; end
          r.hi = m[31:0];
          r.lo = q[31:0];
        end
      end
    endcase
    return r;
  endfunction

  function automatic logic [N-1:0] pickOperand();
    case ($urandom_range(0, 7))
      0:       return 32'h0000_0000;
      1:       return 32'hFFFF_FFFF;
      2:       return 32'h8000_0000;
      3:       return 32'h0000_0001;
      4:       return 32'($urandom_range(0, 15));
      default: return 32'($urandom);
    endcase
  endfunction

  // Issue one operation from a negedge and follow it to its done cycle,
  // returning in that cycle so the next request can go out back-to-back.
  task automatic applyStimulus(input op_t op, input logic [N-1:0] a, input logic [N-1:0] b,
                               input logic [N-1:0] exp_hi, input logic [N-1:0] exp_lo,
                               input bit disturb, input bit mt_at_start);
    exp_t e;
    int   cycles;
    e.hi = exp_hi;
    e.lo = exp_lo;
    bus.op    = op;
    bus.a     = a;
    bus.b     = b;
    bus.start = 1'b1;
    if (mt_at_start) begin
      bus.mthi  = 1'b1;
      bus.mtlo  = 1'b1;
      bus.wdata = 32'($urandom);
    end
    exp_q.push_back(e);
    @(negedge clk);
    bus.start = 1'b0;
    bus.mthi  = 1'b0;
    bus.mtlo  = 1'b0;
    bus.a     = 32'($urandom);
    bus.b     = 32'($urandom);
    checkOutput("busy_after_start", 32'(bus.busy), 32'd1);
    checkOutput("done_low_while_busy", 32'(bus.done), 32'd0);
    cycles = 0;
    while (!bus.done && cycles < 200) begin
      checkOutput("hi_stable", bus.hi, hi_model);
      checkOutput("lo_stable", bus.lo, lo_model);
      if (disturb && cycles == 10) begin
        bus.start = 1'b1;
        bus.mthi  = 1'b1;
        bus.mtlo  = 1'b1;
        bus.wdata = 32'($urandom);
        bus.op    = op_t'($urandom_range(0, 3));
      end else begin
        bus.start = 1'b0;
        bus.mthi  = 1'b0;
        bus.mtlo  = 1'b0;
      end
      @(negedge clk);
      cycles++;
    end
    bus.start = 1'b0;
    bus.mthi  = 1'b0;
    bus.mtlo  = 1'b0;
    checkOutput("done_seen", 32'(bus.done), 32'd1);
    checkOutput("latency", 32'(cycles), 32'(N + 2));
    checkOutput("busy_at_done", 32'(bus.busy), 32'd0);
    hi_model = exp_hi;
    lo_model = exp_lo;
  endtask

  // Write HI and/or LO from an idle negedge and confirm the next cycle.
  task automatic applyMt(input bit wr_hi, input bit wr_lo, input logic [N-1:0] data);
    bus.mthi  = wr_hi;
    bus.mtlo  = wr_lo;
    bus.wdata = data;
    @(negedge clk);
    bus.mthi = 1'b0;
    bus.mtlo = 1'b0;
    if (wr_hi) hi_model = data;
    if (wr_lo) lo_model = data;
    checkOutput("mt_hi", bus.hi, hi_model);
    checkOutput("mt_lo", bus.lo, lo_model);
  endtask

  // Monitor: every done pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (rst_n && bus.done) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("[TB] FAIL unexpected_done: got done=1, expected no pending result");
      end else begin
        mon_exp = exp_q.pop_front();
        checkOutput("result_hi", bus.hi, mon_exp.hi);
        checkOutput("result_lo", bus.lo, mon_exp.lo);
      end
    end
  end

  initial begin
    exp_t r;
    op_t  op;
    logic [N-1:0] a, b;
    checks    = 0;
    errors    = 0;
    hi_model  = '0;
    lo_model  = '0;
    rst_n     = 1'b0;
    bus.start = 1'b0;
    bus.op    = OP_MULT;
    bus.a     = '0;
    bus.b     = '0;
    bus.mthi  = 1'b0;
    bus.mtlo  = 1'b0;
    bus.wdata = '0;
    #1;
    checkOutput("reset_busy", 32'(bus.busy), 32'd0);
    checkOutput("reset_done", 32'(bus.done), 32'd0);
    checkOutput("reset_hi", bus.hi, 32'd0);
    checkOutput("reset_lo", bus.lo, 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    $display("[TB] directed corner cases");
    applyStimulus(OP_MULTU, 32'hFFFF_FFFF, 32'd2,        32'h0000_0001, 32'hFFFF_FFFE, 1'b0, 1'b0);
    applyMt(1'b1, 1'b0, 32'hA5A5_A5A5);
    applyMt(1'b0, 1'b1, 32'h5A5A_0F0F);
    applyMt(1'b1, 1'b1, 32'h1357_9BDF);
    applyStimulus(OP_MULT,  32'hFFFF_FFFD, 32'd7,        32'hFFFF_FFFF, 32'hFFFF_FFEB, 1'b1, 1'b0);
    applyStimulus(OP_DIV,   32'hFFFF_FFF9, 32'd2,        32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0, 1'b1);
    applyStimulus(OP_DIVU,  32'd100,       32'd7,        32'd2,         32'd14,        1'b0, 1'b0);
    applyStimulus(OP_DIVU,  32'h0000_1234, 32'd0,        32'h0000_1234, 32'hFFFF_FFFF, 1'b0, 1'b0);
    applyStimulus(OP_DIV,   32'h8000_0000, 32'hFFFF_FFFF, 32'd0,        32'h8000_0000, 1'b1, 1'b0);
    applyStimulus(OP_DIV,   32'hFFFF_FFF9, 32'd0,        32'hFFFF_FFF9, 32'hFFFF_FFFF, 1'b0, 1'b0);
    applyStimulus(OP_MULT,  32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'd0,        1'b0, 1'b0);

    $display("[TB] randomized operations");
    for (int i = 0; i < 40; i++) begin
      op = op_t'($urandom_range(0, 3));
      a  = pickOperand();
      b  = pickOperand();
      r  = refModel(op, a, b);
      applyStimulus(op, a, b, r.hi, r.lo, (i % 7) == 3, (i % 5) == 1);
    end

    $display("[TB] reset during calculation");
    bus.op    = OP_MULTU;
    bus.a     = 32'h1234_5678;
    bus.b     = 32'h9ABC_DEF0;
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (10) @(negedge clk);
    exp_q.delete();
    rst_n = 1'b0;
    #1;
    checkOutput("abort_busy", 32'(bus.busy), 32'd0);
    checkOutput("abort_done", 32'(bus.done), 32'd0);
    checkOutput("abort_hi", bus.hi, 32'd0);
    checkOutput("abort_lo", bus.lo, 32'd0);
    hi_model = '0;
    lo_model = '0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    r = refModel(OP_MULTU, 32'h0001_0003, 32'h0002_0005);
    applyStimulus(OP_MULTU, 32'h0001_0003, 32'h0002_0005, r.hi, r.lo, 1'b0, 1'b0);
    r = refModel(OP_DIV, 32'h8000_0001, 32'h0000_0003);
    applyStimulus(OP_DIV, 32'h8000_0001, 32'h0000_0003, r.hi, r.lo, 1'b0, 1'b0);

    repeat (3) @(negedge clk);
    checkOutput("done_single_pulse", 32'(bus.done), 32'd0);
    checkOutput("scoreboard_empty", 32'(exp_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
